postmortem_trig_ctrl: RTL and testbench
=======================================

POSTMORTEM_TRIG_CTRL -- requirements
Module: postmortem_trig_ctrl

Interface
REQ-001 SHALL have parameter SRC_NUM, default 16, number of interlock source bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 50000, postmortem buffer depth in samples.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports named i_clk and i_rst.
REQ-004 i_clk  input  1  system clock, 200 MHz.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_intl_src  input  SRC_NUM  interlock sources, synchronous to i_clk, level.
REQ-007 i_intl_mask  input  SRC_NUM  1 = source ignored.
REQ-008 i_post_cnt  input  16  samples recorded after trigger before freeze.
REQ-009 i_arm  input  1  one-cycle pulse, arm/re-arm capture.
REQ-010 i_force_trig  input  1  one-cycle software trigger pulse.
REQ-011 i_sample_tick  input  1  one-cycle pulse per buffer write-address advance.
REQ-012 i_w_ram_addr  input  16  current buffer write address.
REQ-013 o_intl_flag  output  1  freeze; 1 = buffer writes stopped.
REQ-014 o_trig_addr  output  16  write address latched at trigger.
REQ-015 o_stop_addr  output  16  write address latched at freeze.
REQ-016 o_first_fault  output  SRC_NUM  unmasked sources whose edge caused the trigger.
REQ-017 o_fault_latch  output  SRC_NUM  all unmasked edges since trigger.
REQ-018 o_state  output  2  FSM state.
REQ-019 o_done  output  1  one-cycle pulse on entry to FROZEN.
REQ-020 o_trig_cnt  output  16  triggers since reset, saturating at 0xFFFF.

Function
REQ-021 Edge = i_intl_src & ~prev & ~i_intl_mask; prev is i_intl_src registered every cycle in all states.
REQ-022 States: IDLE=0, ARMED=1, POST=2, FROZEN=3.
REQ-023 IDLE: triggers ignored, o_intl_flag=0; i_arm -> ARMED next cycle.
REQ-024 ARMED: any edge bit or i_force_trig -> POST next cycle; i_arm ignored.
REQ-025 On trigger, at the transition cycle+1: o_trig_addr=i_w_ram_addr of trigger cycle, o_first_fault=edge vector (all zero if force only), o_fault_latch=edge vector, o_trig_cnt+1.
REQ-026 POST counter loads min(i_post_cnt, RAM_DEPTH-1) on trigger; decrements on each i_sample_tick.
REQ-027 POST: i_sample_tick with counter==1 -> FROZEN next cycle; loaded count 0 -> FROZEN on cycle after entering POST.
REQ-028 Entry to FROZEN: o_intl_flag=1, o_stop_addr=i_w_ram_addr of the transition cycle, o_done=1 for one cycle.
REQ-029 POST and FROZEN: further edges OR into o_fault_latch; no re-trigger; i_force_trig ignored.
REQ-030 POST: i_arm ignored.
REQ-031 FROZEN: i_arm -> ARMED next cycle, o_intl_flag=0, o_first_fault and o_fault_latch cleared; o_trig_addr, o_stop_addr retained.
REQ-032 Source held high across arm SHALL NOT trigger; a new rising edge is required.
REQ-033 Mask change SHALL take effect the same cycle (combinational in edge term).
REQ-034 Edge and i_sample_tick in same cycle in ARMED: trigger taken, tick not counted.

Reset
REQ-035 On i_rst: state IDLE, prev=0, counter=0, all outputs 0, o_intl_flag=0.
REQ-036 Reset mid-POST or FROZEN SHALL immediately release o_intl_flag and clear latched addresses and faults.

Structure
REQ-037 Shared package postmortem_pkg SHALL hold state encoding constants and RAM_DEPTH default.
REQ-038 One sub-module postmortem_edge_det (prev register, mask, edge vector) SHALL be instantiated.
REQ-039 All outputs SHALL be registered except o_state (direct state register).

Verification
REQ-040 Reset, i_arm, src[3] 0->1 at addr 100, i_post_cnt=5, 5 ticks -> o_trig_addr=100, o_first_fault=0x0008, o_intl_flag=1 one cycle after 5th tick, o_done single pulse.
REQ-041 Masked src[0] edge with mask=0x0001 in ARMED -> no trigger, state stays 1; unmask while high -> no trigger.
REQ-042 i_post_cnt=0, force trigger -> FROZEN two cycles after force, o_first_fault=0, o_trig_cnt=1.
REQ-043 In POST, src[7] edge -> o_fault_latch=first|0x0080, o_first_fault unchanged; i_arm in POST ignored.
REQ-044 FROZEN, i_arm -> o_intl_flag=0, fault vectors 0, state ARMED; i_post_cnt=60000 clamps to 49999 ticks.
REQ-045 Assert i_rst during POST -> all outputs 0, state IDLE asynchronously.

Source files
------------

// File: rtl/postmortem_pkg.sv
// Shared definitions for the postmortem trigger controller.
// Holds the FSM state encoding, the default buffer depth and a helper
// that clamps the requested post-trigger sample count to the buffer size.
package postmortem_pkg;

  // FSM state encoding (also visible on o_state)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_POST   = 2'd2;
  localparam logic [1:0] ST_FROZEN = 2'd3;

  localparam int RAM_DEPTH_DEFAULT = 50000;
  localparam int SRC_NUM_DEFAULT   = 16;

  // Post-trigger count can never exceed the buffer minus one sample,
  // otherwise the freeze would overwrite the trigger point itself.
  function automatic logic [15:0] clamp_post(input logic [15:0] req,
                                             input logic [15:0] max_cnt);
    return (req > max_cnt) ? max_cnt : req;
  endfunction

endpackage

// File: rtl/postmortem_edge_det.sv
// Rising-edge detector for the interlock sources.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   src       : interlock source levels
//   mask      : 1 = source ignored (applied combinationally)
//   edge_vec  : unmasked sources that rose this cycle
// The previous-value register runs every cycle regardless of FSM state, so a
// source that is already high when capture is armed never produces an edge.
module postmortem_edge_det #(
  parameter int SRC_NUM = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] src,
  input  logic [SRC_NUM-1:0] mask,
  output logic [SRC_NUM-1:0] edge_vec
);

  logic [SRC_NUM-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= src;
  end

  // Mask is not registered so a mask change affects the same cycle.
  assign edge_vec = src & ~prev & ~mask;

endmodule

// File: rtl/postmortem_trig_ctrl.sv
// Postmortem buffer trigger controller.
// Arms on i_arm, triggers on the first unmasked interlock rising edge (or a
// software force), records i_post_cnt more samples, then freezes the buffer.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_intl_src       : interlock source levels
//   i_intl_mask      : 1 = source ignored
//   i_post_cnt       : samples to record after trigger
//   i_arm            : arm / re-arm pulse
//   i_force_trig     : software trigger pulse
//   i_sample_tick    : one pulse per buffer write-address advance
//   i_w_ram_addr     : current buffer write address
//   o_intl_flag      : 1 = buffer frozen
//   o_trig_addr      : write address at trigger
//   o_stop_addr      : write address at freeze
//   o_first_fault    : edges that caused the trigger
//   o_fault_latch    : all edges since trigger
//   o_state          : FSM state (IDLE/ARMED/POST/FROZEN)
//   o_done           : one-cycle pulse on entry to FROZEN
//   o_trig_cnt       : saturating trigger count
// Handshake: there is no valid/ready flow control; i_arm, i_force_trig and
// i_sample_tick are single-cycle strobes sampled on every rising clock edge,
// and o_done is a single-cycle strobe that the consumer must catch.
module postmortem_trig_ctrl
  import postmortem_pkg::*;
#(
  parameter int SRC_NUM   = SRC_NUM_DEFAULT,
  parameter int RAM_DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SRC_NUM-1:0] i_intl_src,
  input  logic [SRC_NUM-1:0] i_intl_mask,
  input  logic [15:0]        i_post_cnt,
  input  logic               i_arm,
  input  logic               i_force_trig,
  input  logic               i_sample_tick,
  input  logic [15:0]        i_w_ram_addr,
  output logic               o_intl_flag,
  output logic [15:0]        o_trig_addr,
  output logic [15:0]        o_stop_addr,
  output logic [SRC_NUM-1:0] o_first_fault,
  output logic [SRC_NUM-1:0] o_fault_latch,
  output logic [1:0]         o_state,
  output logic               o_done,
  output logic [15:0]        o_trig_cnt
);

  localparam logic [15:0] POST_MAX = 16'(RAM_DEPTH - 1);

  logic [1:0]         state;
  logic [15:0]        remain;
  logic [SRC_NUM-1:0] edge_vec;
  logic               trig;
  logic               freeze;

  postmortem_edge_det #(.SRC_NUM(SRC_NUM)) u_edge_det (
    .clk      (i_clk),
    .rst      (i_rst),
    .src      (i_intl_src),
    .mask     (i_intl_mask),
    .edge_vec (edge_vec)
  );

  assign trig = (|edge_vec) | i_force_trig;

  // A zero load freezes on the first POST cycle without waiting for a tick;
  // otherwise the tick that consumes the last remaining sample freezes.
  assign freeze = (remain == 16'd0) || (i_sample_tick && remain == 16'd1);

  assign o_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      remain        <= '0;
      o_intl_flag   <= 1'b0;
      o_trig_addr   <= '0;
      o_stop_addr   <= '0;
      o_first_fault <= '0;
      o_fault_latch <= '0;
      o_done        <= 1'b0;
      o_trig_cnt    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_arm) state <= ST_ARMED;
        end
        ST_ARMED: begin
          // A tick coinciding with the trigger is not counted: the counter
          // is loaded, not decremented, on this cycle.
          if (trig) begin
            state         <= ST_POST;
            o_trig_addr   <= i_w_ram_addr;
            o_first_fault <= edge_vec;
            o_fault_latch <= edge_vec;
            remain        <= clamp_post(i_post_cnt, POST_MAX);
            if (o_trig_cnt != 16'hFFFF) o_trig_cnt <= o_trig_cnt + 16'd1;
          end
        end
        ST_POST: begin
          o_fault_latch <= o_fault_latch | edge_vec;
          if (freeze) begin
            state       <= ST_FROZEN;
            remain      <= '0;
            o_intl_flag <= 1'b1;
            o_stop_addr <= i_w_ram_addr;
            o_done      <= 1'b1;
          end else if (i_sample_tick) begin
            remain <= remain - 16'd1;
          end
        end
        ST_FROZEN: begin
          if (i_arm) begin
            state         <= ST_ARMED;
            o_intl_flag   <= 1'b0;
            o_first_fault <= '0;
            o_fault_latch <= '0;
          end else begin
            o_fault_latch <= o_fault_latch | edge_vec;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_postmortem_trig_ctrl.sv
module tb_postmortem_trig_ctrl;

  localparam int SRC_NUM   = 16;
  localparam int RAM_DEPTH = 50000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [SRC_NUM-1:0] src = '0;
  logic [SRC_NUM-1:0] mask = '0;
  logic [15:0]        post_cnt = '0;
  logic               arm = 1'b0;
  logic               force_trig = 1'b0;
  logic               sample_tick = 1'b0;
  logic [15:0]        waddr = '0;

  logic               intl_flag;
  logic [15:0]        trig_addr;
  logic [15:0]        stop_addr;
  logic [SRC_NUM-1:0] first_fault;
  logic [SRC_NUM-1:0] fault_latch;
  logic [1:0]         state;
  logic               done;
  logic [15:0]        trig_cnt;

  postmortem_trig_ctrl #(.SRC_NUM(SRC_NUM), .RAM_DEPTH(RAM_DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_intl_src    (src),
    .i_intl_mask   (mask),
    .i_post_cnt    (post_cnt),
    .i_arm         (arm),
    .i_force_trig  (force_trig),
    .i_sample_tick (sample_tick),
    .i_w_ram_addr  (waddr),
    .o_intl_flag   (intl_flag),
    .o_trig_addr   (trig_addr),
    .o_stop_addr   (stop_addr),
    .o_first_fault (first_fault),
    .o_fault_latch (fault_latch),
    .o_state       (state),
    .o_done        (done),
    .o_trig_cnt    (trig_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 armed, 2 post-trigger recording, 3 frozen.
  // Recording is tracked as "ticks seen since trigger" against "ticks needed".
  int                 m_mode;
  int                 m_need;
  int                 m_seen;
  logic [SRC_NUM-1:0] m_last_src;
  logic [SRC_NUM-1:0] m_rise;
  logic               e_flag;
  logic [15:0]        e_trig_addr;
  logic [15:0]        e_stop_addr;
  logic [SRC_NUM-1:0] e_first;
  logic [SRC_NUM-1:0] e_latch;
  logic               e_done;
  logic [15:0]        e_cnt;

  task automatic model_reset();
    m_mode = 0; m_need = 0; m_seen = 0; m_last_src = '0;
    e_flag = 0; e_trig_addr = '0; e_stop_addr = '0; e_first = '0;
    e_latch = '0; e_done = 0; e_cnt = '0;
  endtask

  task automatic model_freeze();
    m_mode = 3; e_flag = 1'b1; e_stop_addr = waddr; e_done = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      m_rise = src & ~m_last_src & ~mask;
      m_last_src = src;
      e_done = 1'b0;
      if (m_mode == 0) begin
        if (arm) m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_rise != '0 || force_trig) begin
          m_mode = 2;
          e_trig_addr = waddr;
          e_first = m_rise;
          e_latch = m_rise;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
          m_need = (int'(post_cnt) > RAM_DEPTH - 1) ? RAM_DEPTH - 1 : int'(post_cnt);
          m_seen = 0;
        end
      end else if (m_mode == 2) begin
        e_latch = e_latch | m_rise;
        if (m_need == 0) model_freeze();
        else if (sample_tick) begin
          m_seen = m_seen + 1;
          if (m_seen == m_need) model_freeze();
        end
      end else begin
        if (arm) begin
          m_mode = 1; e_flag = 1'b0; e_first = '0; e_latch = '0;
        end else begin
          e_latch = e_latch | m_rise;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    check("state",       32'(state),       32'(m_mode));
    check("intl_flag",   32'(intl_flag),   32'(e_flag));
    check("trig_addr",   32'(trig_addr),   32'(e_trig_addr));
    check("stop_addr",   32'(stop_addr),   32'(e_stop_addr));
    check("first_fault", 32'(first_fault), 32'(e_first));
    check("fault_latch", 32'(fault_latch), 32'(e_latch));
    check("done",        32'(done),        32'(e_done));
    check("trig_cnt",    32'(trig_cnt),    32'(e_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
    arm = 1'b0; force_trig = 1'b0; sample_tick = 1'b0;
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    step();
    waddr = waddr + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    model_reset();
    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_flag", 32'(intl_flag), 32'd0);

    // Trigger on src[3] at address 100, five post samples.
    arm = 1'b1; step();
    check("armed_state", 32'(state), 32'd1);
    waddr = 16'd100; post_cnt = 16'd5; src[3] = 1'b1; step();
    check("s1_state_post", 32'(state), 32'd2);
    check("s1_trig_addr", 32'(trig_addr), 32'd100);
    check("s1_first", 32'(first_fault), 32'h0008);
    for (int i = 0; i < 4; i++) do_tick();
    check("s1_flag_before", 32'(intl_flag), 32'd0);
    do_tick();
    check("s1_flag", 32'(intl_flag), 32'd1);
    check("s1_done", 32'(done), 32'd1);
    check("s1_stop_addr", 32'(stop_addr), 32'd104);
    step();
    check("s1_done_pulse", 32'(done), 32'd0);

    // Re-arm from FROZEN with src[3] still high: no new trigger.
    arm = 1'b1; step();
    check("rearm_state", 32'(state), 32'd1);
    check("rearm_flag", 32'(intl_flag), 32'd0);
    check("rearm_latch", 32'(fault_latch), 32'd0);
    check("rearm_trig_addr_kept", 32'(trig_addr), 32'd100);
    step();
    check("held_high_no_trig", 32'(state), 32'd1);

    // Masked edge, then unmask while high: no trigger.
    mask = 16'h0001; src[0] = 1'b1; step();
    check("masked_no_trig", 32'(state), 32'd1);
    mask = 16'h0000; step(); step();
    check("unmask_no_trig", 32'(state), 32'd1);
    src = '0; step();

    // Trigger on src[2] together with a tick (tick not counted), then src[7].
    post_cnt = 16'd3; src[2] = 1'b1; sample_tick = 1'b1; step();
    check("s4_state_post", 32'(state), 32'd2);
    src[7] = 1'b1; arm = 1'b1; step();
    check("s4_latch", 32'(fault_latch), 32'h0084);
    check("s4_first", 32'(first_fault), 32'h0004);
    check("s4_arm_ignored", 32'(state), 32'd2);
    force_trig = 1'b1; do_tick(); do_tick();
    check("s4_two_ticks", 32'(state), 32'd2);
    do_tick();
    check("s4_frozen", 32'(state), 32'd3);
    src[1] = 1'b1; step();
    check("s4_frozen_latch", 32'(fault_latch), 32'h0086);
    src = '0; step();

    // Fresh reset, zero post count, force trigger.
    do_reset();
    arm = 1'b1; step();
    post_cnt = 16'd0; force_trig = 1'b1; step();
    check("s5_post", 32'(state), 32'd2);
    step();
    check("s5_frozen", 32'(state), 32'd3);
    check("s5_first", 32'(first_fault), 32'd0);
    check("s5_cnt", 32'(trig_cnt), 32'd1);

    // Asynchronous reset in the middle of POST.
    arm = 1'b1; step();
    post_cnt = 16'd10; force_trig = 1'b1; step();
    check("s6_post", 32'(state), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("s6_async_state", 32'(state), 32'd0);
    check("s6_async_trig_addr", 32'(trig_addr), 32'd0);
    check("s6_async_cnt", 32'(trig_cnt), 32'd0);
    step();
    rst = 1'b0; step();

    // Clamp: 60000 requested, 49999 ticks to freeze.
    arm = 1'b1; step();
    post_cnt = 16'd60000; force_trig = 1'b1; step();
    for (int i = 0; i < RAM_DEPTH - 2; i++) do_tick();
    check("s7_not_yet", 32'(state), 32'd2);
    do_tick();
    check("s7_frozen", 32'(state), 32'd3);
    check("s7_done", 32'(done), 32'd1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
